cdb_arbiter: RTL

Writeback arbiter that shares the single result broadcast path (common data bus) between execution units: ALU, load/store buffer and any future units. Each requester pushes completed results (rob index, value, branch outcome, target PC) into a private shallow FIFO. A round-robin scheduler pops one entry per cycle onto a registered CDB that feeds the reorder buffer, reservation station and LSB wakeup. Flushes on misprediction clear.

---
 rtl/cdb_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the single common data bus between execution units. Each
//   requester pushes finished results into a private circular FIFO. A
//   round-robin scheduler pops at most one head entry per cycle and
//   registers it onto the CDB, which feeds the ROB, the reservation
//   stations and the LSB wakeup logic.
//
// Ports
//   clk_in         clock, rising edge
//   rst_in         asynchronous active-high reset
//   rdy_in         global enable; every register holds while low
//   flush_in       misprediction clear (synchronous, qualified by rdy_in)
//   req_valid      per-requester entry strobe
//   req_ready      per-requester FIFO not full (from state only)
//   req_result     packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_rob_index  packed destination rob indices, same packing
//   req_branch     per-requester branch-taken flag
//   req_newpc      packed resolved targets, same packing
//   cdb_*          registered broadcast (valid, result, rob index,
//                  branch, new pc, one-hot source grant)
//   busy           any FIFO holds an entry
module cdb_arbiter #(
   parameter int NREQ      = 3,
   parameter int DATA_W    = 32,
   parameter int ROB_IDX_W = 4,
   parameter int QDEPTH    = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      flush_in,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*DATA_W-1:0]    req_result,
   input  logic [NREQ*ROB_IDX_W-1:0] req_rob_index,
   input  logic [NREQ-1:0]           req_branch,
   input  logic [NREQ*DATA_W-1:0]    req_newpc,
   output logic                      cdb_valid,
   output logic [DATA_W-1:0]         cdb_result,
   output logic [ROB_IDX_W-1:0]      cdb_rob_index,
   output logic                      cdb_branch,
   output logic [DATA_W-1:0]         cdb_newpc,
   output logic [NREQ-1:0]           cdb_grant,
   output logic                      busy
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RR_W  = $clog2(NREQ);

   typedef struct packed {
      logic [DATA_W-1:0]    result;
      logic [ROB_IDX_W-1:0] rob_index;
      logic                 branch;
      logic [DATA_W-1:0]    newpc;
   } entry_t;

   entry_t           fifo_mem [NREQ][QDEPTH];
   logic [PTR_W-1:0] wr_ptr   [NREQ];
   logic [PTR_W-1:0] rd_ptr   [NREQ];
   logic [CNT_W-1:0] count    [NREQ];
   logic [RR_W-1:0]  rr_ptr;

   logic [NREQ-1:0]  nonempty;
   logic [NREQ-1:0]  push;
   logic [NREQ-1:0]  pop;
   logic             fire;
   logic             win_found;
   logic [RR_W-1:0]  win_idx;
   entry_t           head;

   // (base + k) mod NREQ; both operands are below NREQ, so one subtract suffices.
   function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return RR_W'(s);
   endfunction

   assign fire = rdy_in && !flush_in;
   assign busy = |nonempty;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         nonempty[i]  = (count[i] != '0);
         // A full FIFO stays not-ready even when it is popped this cycle.
         req_ready[i] = (count[i] != CNT_W'(QDEPTH));
      end
   end

   // Candidates are taken from the pre-edge counts, so an entry pushed this
   // edge cannot be granted on the same edge.
   always_comb begin
      // NOTE: defaults first so no path leaves win_found/win_idx unassigned (no latch);
      // blocking assignments let later iterations see the found flag.
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found && nonempty[rr_add(rr_ptr, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_add(rr_ptr, k);
         end
      end
   end

   assign head = fifo_mem[win_idx][rd_ptr[win_idx]];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         push[i] = fire && req_valid[i] && req_ready[i];
         pop[i]  = fire && win_found && (win_idx == RR_W'(i));
      end
   end

   // NOTE: FIFO storage carries no reset; count gates every read, so stale data is never seen.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NREQ; i++) begin
         if (push[i]) begin
            fifo_mem[i][wr_ptr[i]] <= '{result:    req_result[i*DATA_W +: DATA_W],
                                        rob_index: req_rob_index[i*ROB_IDX_W +: ROB_IDX_W],
                                        branch:    req_branch[i],
                                        newpc:     req_newpc[i*DATA_W +: DATA_W]};
         end
      end
   end

   // Pointers and occupancy. Push and pop on the same FIFO leave count alone.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREQ; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 0; i < NREQ; i++) begin
            if (flush_in) begin
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
               count[i]  <= '0;
            end else begin
               if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
               if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
               case ({push[i], pop[i]})
                  2'b10:   count[i] <= count[i] + CNT_W'(1);
                  2'b01:   count[i] <= count[i] - CNT_W'(1);
                  default: count[i] <= count[i];
               endcase
            end
         end
      end
   end

   // Registered broadcast. With no candidate the payload and rr_ptr hold,
   // only the strobe and grant drop.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cdb_valid     <= 1'b0;
         cdb_result    <= '0;
         cdb_rob_index <= '0;
         cdb_branch    <= 1'b0;
         cdb_newpc     <= '0;
         cdb_grant     <= '0;
         rr_ptr        <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            cdb_valid <= 1'b0;
            cdb_grant <= '0;
            rr_ptr    <= '0;
         end else if (win_found) begin
            cdb_valid     <= 1'b1;
            cdb_result    <= head.result;
            cdb_rob_index <= head.rob_index;
            cdb_branch    <= head.branch;
            cdb_newpc     <= head.newpc;
            cdb_grant     <= NREQ'(1) << win_idx;
            rr_ptr        <= rr_add(win_idx, 1);
         end else begin
            cdb_valid <= 1'b0;
            cdb_grant <= '0;
         end
      end
   end

endmodule
